// File: rtl/screen_painter.sv
// Full-screen painter: walks every framebuffer pixel once per start, emitting x/y/colour/plot.
// Optional transparent-key overlay in KEYED mode is enabled by defining SCREEN_PAINTER_KEY_EN.
module screen_painter #(
    parameter int                     WIDTH       = 160,
    parameter int                     HEIGHT      = 120,
    parameter int                     X_BITS      = 8,
    parameter int                     Y_BITS      = 7,
    parameter int                     ADDR_BITS   = 15,
    parameter int                     COLOUR_BITS = 3,
    parameter logic [COLOUR_BITS-1:0] KEY_COLOUR  = 3'b100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COLOUR_BITS-1:0] fillColour,
    output logic [ADDR_BITS-1:0]   romAddr,
    input  logic [COLOUR_BITS-1:0] romData,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colourOut,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_IMAGE = 2'b01;
    localparam logic [1:0] MODE_KEYED = 2'b10;

    localparam logic [X_BITS-1:0] LAST_X = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] LAST_Y = Y_BITS'(HEIGHT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [X_BITS-1:0]      cx;
    logic [Y_BITS-1:0]      cy;
    logic [1:0]             mode_q;
    logic [COLOUR_BITS-1:0] fill_q;
    logic                   last_pixel;

    assign last_pixel = (cx == LAST_X) && (cy == LAST_Y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_pixel) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters run one cycle ahead of x/y/plot to line up with the ROM's read latency.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx      <= '0;
            cy      <= '0;
            romAddr <= '0;
            x       <= '0;
            y       <= '0;
            plot    <= 1'b0;
            mode_q  <= '0;
            fill_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    plot <= 1'b0;
                    if (start) begin
                        mode_q  <= mode;
                        fill_q  <= fillColour;
                        cx      <= '0;
                        cy      <= '0;
                        romAddr <= '0;
                    end
                end
                S_RUN: begin
                    romAddr <= romAddr + ADDR_BITS'(1);
                    if (cx == LAST_X) begin
                        cx <= '0;
                        cy <= cy + Y_BITS'(1);
                    end else begin
                        cx <= cx + X_BITS'(1);
                    end
                    x    <= cx;
                    y    <= cy;
                    plot <= 1'b1;
                end
                default: begin
                    plot <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCREEN_PAINTER_KEY_EN
    logic key_hit;
    assign key_hit = (romData == KEY_COLOUR);
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOUR;
`endif

    always_comb begin
        colourOut = fill_q;
        case (mode_q)
            MODE_IMAGE: colourOut = romData;
`ifdef SCREEN_PAINTER_KEY_EN
            MODE_KEYED: colourOut = key_hit ? fill_q : romData;
`else
            MODE_KEYED: colourOut = romData;
`endif
            default:    colourOut = fill_q;
        endcase
    end

endmodule

// File: tb/tb_screen_painter.sv
// Directed bench for screen_painter: a 4x3 instance for mode/handshake cases and a
// default-size instance for the full IMAGE frame and asynchronous mid-frame reset.
module tb_screen_painter;

    localparam int SN = 12;
    localparam int BN = 160 * 120;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        start_s, start_b;
    logic [1:0]  mode_s, mode_b;
    logic [2:0]  fill_s, fill_b;
    logic [14:0] s_rom_addr, b_rom_addr;
    logic [2:0]  s_rom_data, b_rom_data;
    logic [7:0]  s_x, b_x;
    logic [6:0]  s_y, b_y;
    logic [2:0]  s_colour, b_colour;
    logic        s_plot, b_plot, s_busy, b_busy, s_done, b_done;

    int total = 0;
    int bad   = 0;

    screen_painter #(.WIDTH(4), .HEIGHT(3)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .mode(mode_s), .fillColour(fill_s),
        .romAddr(s_rom_addr), .romData(s_rom_data), .x(s_x), .y(s_y),
        .colourOut(s_colour), .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    screen_painter dut_big (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .fillColour(fill_b),
        .romAddr(b_rom_addr), .romData(b_rom_data), .x(b_x), .y(b_y),
        .colourOut(b_colour), .plot(b_plot), .busy(b_busy), .done(b_done)
    );

    // Synchronous ROMs with one cycle of latency.
    always @(posedge clk) begin
        s_rom_data <= s_rom_addr[0] ? 3'b011 : 3'b100;
        b_rom_data <= b_rom_addr[2:0];
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] small_colour(input logic [1:0] m, input logic [2:0] f, input int k);
        logic [2:0] rom;
        rom = (k % 2 == 1) ? 3'b011 : 3'b100;
        case (m)
            2'b01: return rom;
`ifdef SCREEN_PAINTER_KEY_EN
            2'b10: return (rom == 3'b100) ? f : rom;
`else
            2'b10: return rom;
`endif
            default: return f;
        endcase
    endfunction

    // Paint one 4x3 frame starting now (cycle 0); optionally hold start high throughout.
    task automatic run_small(input logic [1:0] m, input logic [2:0] f, input bit hold);
        int  k;
        bit  seen;
        start_s = 1'b1;
        mode_s  = m;
        fill_s  = f;
        for (int c = 1; c <= SN + 4; c++) begin
            @(posedge clk); #1;
            if (!hold) start_s = 1'b0;
            if (c == 2) begin
                mode_s = m ^ 2'b01;
                fill_s = ~f;
            end
            check("s_busy", s_busy, ((c <= SN + 1) || (hold && c == SN + 4)) ? 1 : 0);
            check("s_plot", s_plot, (c >= 2 && c <= SN + 1) ? 1 : 0);
            check("s_done", s_done, (c == SN + 2) ? 1 : 0);
            if (c <= SN) check("s_addr", s_rom_addr, c - 1);
            if (c >= 2 && c <= SN + 1) begin
                k = c - 2;
                check("s_x", s_x, k % 4);
                check("s_y", s_y, k / 4);
                check("s_colour", s_colour, small_colour(m, f, k));
            end
        end
        if (hold) begin
            start_s = 1'b0;
            seen    = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(posedge clk); #1;
                seen = s_done;
            end
            check("s_second_done", seen, 1);
            @(posedge clk); #1;
            check("s_idle_after", s_busy, 0);
        end
    endtask

    initial begin
        int busy_hits;
        int done_hits;

        rst = 1'b0;
        start_s = 1'b0; mode_s = 2'b00; fill_s = 3'b000;
        start_b = 1'b0; mode_b = 2'b00; fill_b = 3'b000;
        #2;
        check("rst_plot", s_plot, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_addr", b_rom_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_small(2'b00, 3'b010, 1'b0);
        run_small(2'b01, 3'b110, 1'b0);
        run_small(2'b10, 3'b000, 1'b0);
        run_small(2'b11, 3'b001, 1'b0);
        run_small(2'b00, 3'b101, 1'b1);

        // Full default-size IMAGE frame.
        start_b = 1'b1;
        mode_b  = 2'b01;
        fill_b  = 3'b111;
        for (int c = 1; c <= BN + 3; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            check("b_busy", b_busy, (c <= BN + 1) ? 1 : 0);
            check("b_plot", b_plot, (c >= 2 && c <= BN + 1) ? 1 : 0);
            check("b_done", b_done, (c == BN + 2) ? 1 : 0);
            if (c <= BN) check("b_addr", b_rom_addr, c - 1);
            if (c >= 2 && c <= BN + 1) begin
                check("b_x", b_x, (c - 2) % 160);
                check("b_y", b_y, (c - 2) / 160);
                check("b_colour", b_colour, (c - 2) % 8);
            end
        end

        // Asynchronous reset while pixel 50 is on the outputs.
        start_b = 1'b1;
        mode_b  = 2'b00;
        for (int c = 1; c <= 52; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
        end
        check("mid_x_before", b_x, 50);
        check("mid_plot_before", b_plot, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_plot", b_plot, 0);
        check("mid_busy", b_busy, 0);
        check("mid_done", b_done, 0);
        check("mid_x", b_x, 0);
        check("mid_y", b_y, 0);
        check("mid_addr", b_rom_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        busy_hits = 0;
        done_hits = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (b_busy || b_plot) busy_hits++;
            if (b_done) done_hits++;
        end
        check("post_rst_busy", busy_hits, 0);
        check("post_rst_done", done_hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
